// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: payload field layout and
// the skid buffer occupancy states.
package alu_result_stage_pkg;

  // Payload bit positions. The result word sits above the four flag bits.
  localparam int PL_CO     = 0;
  localparam int PL_V      = 1;
  localparam int PL_N      = 2;
  localparam int PL_Z      = 3;
  localparam int PL_SC_LSB = 4;

  // Buffer occupancy: nothing held, main register held, main and skid held.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Payload width for a given result width: result word plus N, V, Co, Z.
  function automatic int payload_width(input int bits);
    return bits + 4;
  endfunction

endpackage

// File: rtl/alu_result_stage_skid_buffer.sv
// Two-entry skid buffer with a registered in_ready.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   BUF_EMPTY | no data held, out_valid low
//   BUF_ONE   | main register holds the head entry
//   BUF_FULL  | main holds the head, skid holds the next entry
//
// in_ready comes from a flop, so out_ready never reaches in_ready
// combinationally. The skid entry absorbs the one word that can arrive
// while in_ready is still high from the previous cycle.
module skid_buffer
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  buf_state_e        state_q;
  buf_state_e        state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              accept;
  logic              transfer;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign transfer  = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

  // Next occupancy and which register gets loaded from where.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d      = BUF_ONE;
          load_main_in = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && !transfer) begin
          state_d   = BUF_FULL;
          load_skid = 1'b1;
        end else if (transfer && !accept) begin
          state_d = BUF_EMPTY;
        end else if (transfer && accept) begin
          load_main_in = 1'b1;
        end
      end
      BUF_FULL: begin
        if (transfer) begin
          state_d        = BUF_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // Occupancy register; in_ready looks one state ahead so it is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_FULL);
    end
  end

  // Data registers; cleared on reset so the output word reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage after the ALU: captures result and flags,
// derives Z at capture, buffers through a skid buffer, and keeps sticky
// overflow/carry flags plus a saturating accepted-result counter.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int bits  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [bits-1:0]  in_sc,
  input  logic             in_n,
  input  logic             in_v,
  input  logic             in_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [bits-1:0]  out_sc,
  output logic             out_n,
  output logic             out_v,
  output logic             out_co,
  output logic             out_z,
  output logic             sticky_v,
  output logic             sticky_co,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] acc_count
);

  localparam int PL_W = payload_width(bits);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PL_W-1:0] in_payload;
  logic [PL_W-1:0] out_payload;
  logic            accept;

  assign in_payload = {in_sc, (in_sc == '0), in_n, in_v, in_co};
  assign accept     = in_valid & in_ready;

  skid_buffer #(
    .DATA_W(PL_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign out_sc = out_payload[PL_SC_LSB +: bits];
  assign out_z  = out_payload[PL_Z];
  assign out_n  = out_payload[PL_N];
  assign out_v  = out_payload[PL_V];
  assign out_co = out_payload[PL_CO];

  // Sticky flags: a set from an accepted result beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v  <= 1'b0;
      sticky_co <= 1'b0;
    end else begin
      sticky_v  <= (sticky_v  & ~clr_sticky) | (accept & in_v);
      sticky_co <= (sticky_co & ~clr_sticky) | (accept & in_co);
    end
  end

  // Accepted-result counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_count <= '0;
    end else if (accept && (acc_count != CNT_MAX)) begin
      acc_count <= acc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_sc = '0;
  logic       in_n = 1'b0, in_v = 1'b0, in_co = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_sticky = 1'b0;

  logic       in_ready, out_valid, out_n, out_v, out_co, out_z, sticky_v, sticky_co;
  logic [3:0] out_sc;
  logic [7:0] acc_count;

  logic       in_ready2, out_valid2, out_n2, out_v2, out_co2, out_z2, sticky_v2, sticky_co2;
  logic [3:0] out_sc2;
  logic [1:0] acc_count2;

  alu_result_stage #(.bits(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sc(in_sc), .in_n(in_n), .in_v(in_v), .in_co(in_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_sc(out_sc),
    .out_n(out_n), .out_v(out_v), .out_co(out_co), .out_z(out_z),
    .sticky_v(sticky_v), .sticky_co(sticky_co), .clr_sticky(clr_sticky),
    .acc_count(acc_count)
  );

  alu_result_stage #(.bits(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_sc(in_sc), .in_n(in_n), .in_v(in_v), .in_co(in_co),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sc(out_sc2),
    .out_n(out_n2), .out_v(out_v2), .out_co(out_co2), .out_z(out_z2),
    .sticky_v(sticky_v2), .sticky_co(sticky_co2), .clr_sticky(clr_sticky),
    .acc_count(acc_count2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: a FIFO of at most two results plus plain counters.
  typedef struct {
    logic [3:0] sc;
    logic n, v, co, z;
  } result_t;

  result_t m_q[$];
  logic    m_ready = 1'b0;
  logic    m_sv = 1'b0, m_sco = 1'b0;
  int      m_accepts = 0;

  function automatic int exp_cnt(input int maxv);
    return (m_accepts > maxv) ? maxv : m_accepts;
  endfunction

  function automatic logic [7:0] head_word();
    result_t r;
    r = m_q[0];
    return {r.sc, r.n, r.v, r.co, r.z};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ready   = 1'b0;
    m_sv      = 1'b0;
    m_sco     = 1'b0;
    m_accepts = 0;
  endtask

  // Drive one cycle of inputs and advance the model across the edge.
  task automatic step(input logic v, input logic [3:0] sc, input logic n,
                      input logic vf, input logic co, input logic ordy,
                      input logic clr);
    logic acc, xfer;
    result_t r;
    @(negedge clk);
    in_valid = v; in_sc = sc; in_n = n; in_v = vf; in_co = co;
    out_ready = ordy; clr_sticky = clr;
    acc  = v & m_ready;
    xfer = (m_q.size() > 0) & ordy;
    @(posedge clk);
    if (xfer) void'(m_q.pop_front());
    if (acc) begin
      r.sc = sc; r.n = n; r.v = vf; r.co = co; r.z = (sc == 4'd0);
      m_q.push_back(r);
      m_accepts++;
    end
    if (clr) begin m_sv = 1'b0; m_sco = 1'b0; end
    if (acc && vf) m_sv = 1'b1;
    if (acc && co) m_sco = 1'b1;
    m_ready = (m_q.size() < 2);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if ({out_sc, out_n, out_v, out_co, out_z} !== 8'h00) begin bad++; $display("FAIL reset_out_word got=%h exp=00", {out_sc, out_n, out_v, out_co, out_z}); end
    total++; if ({sticky_v, sticky_co} !== 2'b00) begin bad++; $display("FAIL reset_sticky got=%b exp=00", {sticky_v, sticky_co}); end
    total++; if (acc_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", acc_count); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_pass();
    step(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if ({out_sc, out_n, out_v, out_co, out_z} !== {4'b1000, 4'b1100}) begin bad++; $display("FAIL single_word got=%h exp=%h", {out_sc, out_n, out_v, out_co, out_z}, {4'b1000, 4'b1100}); end
    total++; if (sticky_v !== 1'b1) begin bad++; $display("FAIL single_sticky_v got=%b exp=1", sticky_v); end
    total++; if (acc_count !== 8'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", acc_count); end
    idle(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_carry();
    step(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    total++; if (out_z !== 1'b1) begin bad++; $display("FAIL zero_z got=%b exp=1", out_z); end
    total++; if (out_co !== 1'b1) begin bad++; $display("FAIL zero_co got=%b exp=1", out_co); end
    total++; if (sticky_co !== 1'b1) begin bad++; $display("FAIL zero_sticky_co got=%b exp=1", sticky_co); end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    int base;
    logic [3:0] seen[3];
    base = m_accepts;
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after1 got=%b exp=1", in_ready); end
    step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after2 got=%b exp=0", in_ready); end
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (acc_count !== 8'(base + 2)) begin bad++; $display("FAIL bp_held_off_count got=%0d exp=%0d", acc_count, base + 2); end
    total++; if (out_sc !== 4'd1) begin bad++; $display("FAIL bp_stable_head got=%0d exp=1", out_sc); end
    seen[0] = out_sc;
    idle(1'b1);
    seen[1] = out_sc;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_reopen got=%b exp=1", in_ready); end
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    seen[2] = out_sc;
    total++; if ({seen[0], seen[1], seen[2]} !== {4'd1, 4'd2, 4'd3}) begin bad++; $display("FAIL bp_order got=%h exp=123", {seen[0], seen[1], seen[2]}); end
    total++; if (acc_count !== 8'(base + 3)) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", acc_count, base + 3); end
    idle(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sticky_race();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++; if ({sticky_v, sticky_co} !== 2'b00) begin bad++; $display("FAIL race_clear got=%b exp=00", {sticky_v, sticky_co}); end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    total++; if (sticky_v !== 1'b1) begin bad++; $display("FAIL race_set_wins got=%b exp=1", sticky_v); end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (sticky_v !== 1'b0) begin bad++; $display("FAIL race_clear_after got=%b exp=0", sticky_v); end
  endtask

  task automatic test_saturation();
    test_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 7), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (acc_count2 !== 2'd3) begin bad++; $display("FAIL sat_count2 got=%0d exp=3", acc_count2); end
    total++; if (acc_count !== 8'd5) begin bad++; $display("FAIL sat_count8 got=%0d exp=5", acc_count); end
    idle(1'b1);
  endtask

  task automatic test_random();
    logic [3:0] sc;
    for (int i = 0; i < 600; i++) begin
      sc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) sc = 4'd0;
      step(1'($urandom_range(0, 3) != 0), sc, 1'($urandom), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0));
      total++; if (out_valid !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, m_q.size() > 0); end
      total++; if (in_ready !== m_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, m_ready); end
      if (m_q.size() > 0) begin
        total++; if ({out_sc, out_n, out_v, out_co, out_z} !== head_word()) begin bad++; $display("FAIL rnd_word cyc=%0d got=%h exp=%h", i, {out_sc, out_n, out_v, out_co, out_z}, head_word()); end
      end
      total++; if ({sticky_v, sticky_co} !== {m_sv, m_sco}) begin bad++; $display("FAIL rnd_sticky cyc=%0d got=%b exp=%b", i, {sticky_v, sticky_co}, {m_sv, m_sco}); end
      total++; if (acc_count !== 8'(exp_cnt(255))) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, acc_count, exp_cnt(255)); end
      total++; if (acc_count2 !== 2'(exp_cnt(3))) begin bad++; $display("FAIL rnd_count2 cyc=%0d got=%0d exp=%0d", i, acc_count2, exp_cnt(3)); end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (m_q.size() !== 2 || out_valid !== 1'b1) begin bad++; $display("FAIL mid_full_setup got=%b exp=1", out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    total++; if (acc_count !== 8'd0 || acc_count2 !== 2'd0) begin bad++; $display("FAIL mid_count got=%0d/%0d exp=0/0", acc_count, acc_count2); end
    total++; if ({sticky_v, sticky_co} !== 2'b00) begin bad++; $display("FAIL mid_sticky got=%b exp=00", {sticky_v, sticky_co}); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_replay got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_zero_carry();
    test_backpressure();
    test_sticky_race();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
